// File: rtl/sram_test_pkg.sv
// Shared types and constants for the SRAM march tester: FSM encoding, pattern codes
// and the checkerboard / saturation constants.
package sram_test_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrWait,
        StRdReq,
        StRdWait,
        StCheck,
        StDone
    } state_e;

    localparam logic [1:0] PAT_ZERO = 2'b00;
    localparam logic [1:0] PAT_ONE  = 2'b01;
    localparam logic [1:0] PAT_CHK  = 2'b10;
    localparam logic [1:0] PAT_ADDR = 2'b11;

    localparam logic [15:0] CHK_EVEN    = 16'h5555;
    localparam logic [15:0] CHK_ODD     = 16'hAAAA;
    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sram_test_pattern.sv
// Combinational pattern generator shared by the write-data and read-compare paths.
// invert yields the bitwise complement used by the optional inverted passes.
module sram_test_pattern
    import sram_test_pkg::*;
#(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16
) (
    input  logic [1:0]        pat_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic              invert,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] base;

    always_comb begin
        base = '0;
        case (pat_sel)
            PAT_ZERO: base = '0;
            PAT_ONE:  base = '1;
            PAT_CHK:  base = addr[0] ? DATA_W'(CHK_ODD) : DATA_W'(CHK_EVEN);
            // Size cast truncates or zero-extends the address as needed
            PAT_ADDR: base = DATA_W'(addr);
            default:  base = '0;
        endcase
        word = base ^ {DATA_W{invert}};
    end

endmodule

// File: rtl/sram_march_tester.sv
// Self-running SRAM fill/verify engine driving the sram_ctrl request port.
// Optional SRAM_TEST_INVERT_PASS_EN adds a complemented write/read pass pair.
module sram_march_tester
    import sram_test_pkg::*;
#(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LAST_ADDR = 2 ** ADDR_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        pat_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              mem,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_f2s,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_s2f_r
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LAST_ADDR);

    state_e            state_q, state_d;
    logic [1:0]        pat_q, pat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [DATA_W-1:0] cmp_q, cmp_d;
    logic [DATA_W-1:0] pat_word;
    logic              invert;
    logic              at_last;

`ifdef SRAM_TEST_INVERT_PASS_EN
    logic inv_q, inv_d;
    assign invert = inv_q;
`else
    assign invert = 1'b0;
`endif

    assign at_last = (addr_q == LastAddr);

    sram_test_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern (
        .pat_sel (pat_q),
        .addr    (addr_q),
        .invert  (invert),
        .word    (pat_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pat_q   <= PAT_ZERO;
            addr_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            cmp_q   <= '0;
`ifdef SRAM_TEST_INVERT_PASS_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            first_q <= first_d;
            cmp_q   <= cmp_d;
`ifdef SRAM_TEST_INVERT_PASS_EN
            inv_q   <= inv_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        addr_d  = addr_q;
        err_d   = err_q;
        first_d = first_q;
        cmp_d   = cmp_q;
        mem     = 1'b0;
`ifdef SRAM_TEST_INVERT_PASS_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    pat_d   = pat_sel;
                    addr_d  = '0;
                    err_d   = '0;
                    first_d = '0;
`ifdef SRAM_TEST_INVERT_PASS_EN
                    inv_d   = 1'b0;
`endif
                    state_d = StWrReq;
                end
            end
            StWrReq: begin
                mem = ready;
                if (ready) state_d = StWrWait;
            end
            StWrWait: begin
                if (ready) begin
                    if (at_last) begin
                        addr_d  = '0;
                        state_d = StRdReq;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = StWrReq;
                    end
                end
            end
            StRdReq: begin
                mem = ready;
                if (ready) state_d = StRdWait;
            end
            StRdWait: begin
                if (ready) begin
                    cmp_d   = data_s2f_r;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (cmp_q != pat_word) begin
                    if (err_q != ERR_CNT_MAX) err_d = err_q + 16'd1;
                    if (err_q == '0) first_d = addr_q;
                end
                if (at_last) begin
`ifdef SRAM_TEST_INVERT_PASS_EN
                    // First read pass done: rerun write/read with the complement
                    if (!inv_q) begin
                        inv_d   = 1'b1;
                        addr_d  = '0;
                        state_d = StWrReq;
                    end else begin
                        state_d = StDone;
                    end
`else
                    state_d = StDone;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StRdReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy           = (state_q != StIdle) && (state_q != StDone);
    assign done           = (state_q == StDone);
    assign pass           = done && (err_q == '0);
    assign err_cnt        = err_q;
    assign first_err_addr = first_q;
    // Idle bus reads as a read
    assign rw             = (state_q != StWrReq);
    assign addr           = addr_q;
    assign data_f2s       = (state_q == StWrReq) ? pat_word : '0;

endmodule

// File: tb/tb_sram_march_tester.sv
// Scoreboard bench for sram_march_tester against a behavioural sram_ctrl + 8-word SRAM
// with a 2-cycle busy window per operation; honours SRAM_TEST_INVERT_PASS_EN.
module tb_sram_march_tester;

    localparam int AW  = 3;
    localparam int DW  = 16;
    localparam int LAT = 2;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct packed {
        logic          pass;
        logic [15:0]   err;
        logic [AW-1:0] first;
    } res_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    pat_sel = 2'b00;
    logic          busy, done, pass, mem, rw, ready;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr, addr;
    logic [DW-1:0] data_f2s, data_s2f_r;

    always #5 clk = ~clk;

    sram_march_tester #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .LAST_ADDR (7)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .pat_sel        (pat_sel),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .mem            (mem),
        .rw             (rw),
        .addr           (addr),
        .data_f2s       (data_f2s),
        .ready          (ready),
        .data_s2f_r     (data_s2f_r)
    );

    // Behavioural sram_ctrl + SRAM; fault_mode 1 flips bit 3 at addr 5, 2 reads all zero
    logic [DW-1:0] sram [8];
    int            cnt;
    logic          op_rw;
    logic [AW-1:0] op_a;
    logic [DW-1:0] op_d;
    int            fault_mode = 0;
    logic          stall_req = 1'b0;

    function automatic logic [DW-1:0] rd_val(logic [AW-1:0] a);
        case (fault_mode)
            1:       return (a == 3'd5) ? (sram[a] ^ 16'h0008) : sram[a];
            2:       return 16'h0000;
            default: return sram[a];
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready      <= 1'b1;
            cnt        <= 0;
            data_s2f_r <= '0;
        end else if (mem && ready) begin
            ready <= 1'b0;
            cnt   <= stall_req ? 19 : LAT - 1;
            op_rw <= rw;
            op_a  <= addr;
            op_d  <= data_f2s;
        end else if (!ready) begin
            if (cnt == 0) begin
                ready <= 1'b1;
                if (op_rw) data_s2f_r <= rd_val(op_a);
                else sram[op_a] <= op_d;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    req_t req_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_now(string name);
        n_checks++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    function automatic logic [DW-1:0] pw(logic [1:0] p, logic [AW-1:0] a, logic inv);
        logic [DW-1:0] w;
        case (p)
            2'b00:   w = 16'h0000;
            2'b01:   w = 16'hFFFF;
            2'b10:   w = a[0] ? 16'hAAAA : 16'h5555;
            default: w = {13'b0, a};
        endcase
        return w ^ {DW{inv}};
    endfunction

    task automatic push_pass(logic [1:0] p, logic inv);
        for (int i = 0; i < 8; i++) req_q.push_back('{1'b0, AW'(i), pw(p, AW'(i), inv)});
        for (int i = 0; i < 8; i++) req_q.push_back('{1'b1, AW'(i), 16'h0000});
    endtask

    task automatic push_run(logic [1:0] p);
        push_pass(p, 1'b0);
`ifdef SRAM_TEST_INVERT_PASS_EN
        push_pass(p, 1'b1);
`endif
    endtask

    // Monitor: every accepted request and every rising done is scored
    initial begin
        logic done_prev;
        req_t act_r, exp_r;
        res_t act_s, exp_s;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                done_prev = 1'b0;
            end else begin
                if (mem && !ready) fail_now("mem_without_ready");
                if (mem && ready) begin
                    act_r = '{rw, addr, rw ? 16'h0000 : data_f2s};
                    if (req_q.size() == 0) fail_now("unexpected_request");
                    else begin
                        exp_r = req_q.pop_front();
                        check("request", 64'(act_r), 64'(exp_r));
                    end
                end
                if (done && !done_prev) begin
                    act_s = '{pass, err_cnt, first_err_addr};
                    if (res_q.size() == 0) fail_now("unexpected_done");
                    else begin
                        exp_s = res_q.pop_front();
                        check("result", 64'(act_s), 64'(exp_s));
                    end
                end
                done_prev = done;
            end
        end
    end

    task automatic do_start(logic [1:0] p, bit run, bit has_res, res_t r);
        @(negedge clk);
        start   = 1'b1;
        pat_sel = p;
        if (run) push_run(p);
        if (has_res) res_q.push_back(r);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(string name);
        int k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!done) fail_now(name);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(string name);
        check(name, 64'({busy, done, pass, err_cnt, first_err_addr, mem, rw, addr, data_f2s}),
              64'({3'b000, 16'h0000, 3'h0, 1'b0, 1'b1, 3'h0, 16'h0000}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a0;
        logic          held;
        int            k;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset_values");
        reset = 1'b1;

        // Checkerboard, clean memory
        fault_mode = 0;
        do_start(2'b10, 1, 1, '{1'b1, 16'd0, 3'd0});
        wait_done("timeout_chk");

        // Address-in-data, bit 3 of addr 5 flipped on readback
        fault_mode = 1;
`ifdef SRAM_TEST_INVERT_PASS_EN
        do_start(2'b11, 1, 1, '{1'b0, 16'd2, 3'd5});
`else
        do_start(2'b11, 1, 1, '{1'b0, 16'd1, 3'd5});
`endif
        wait_done("timeout_flip");

        // Ones, all reads return zero; inverted pass (zeros) is clean
        fault_mode = 2;
        do_start(2'b01, 1, 1, '{1'b0, 16'd8, 3'd0});
        wait_done("timeout_zero");

        // Restart from DONE clears results; start mid-write is ignored
        fault_mode = 0;
        do_start(2'b00, 1, 1, '{1'b1, 16'd0, 3'd0});
        check("restart_clear", 64'({done, busy, err_cnt, first_err_addr}),
              64'({1'b0, 1'b1, 16'h0000, 3'h0}));
        repeat (6) @(negedge clk);
        do_start(2'b11, 0, 0, '{1'b0, 16'd0, 3'd0});
        check("busy_after_ignored_start", 64'(busy), 64'(1));
        wait_done("timeout_restart");

        // Controller holds ready low for 20 cycles after one acceptance
        do_start(2'b10, 1, 1, '{1'b1, 16'd0, 3'd0});
        k = 0;
        while (!(mem && ready) && k < 100) begin
            @(negedge clk);
            k++;
        end
        stall_req = 1'b1;
        @(negedge clk);
        stall_req = 1'b0;
        a0   = addr;
        held = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if (mem || addr !== a0 || !busy) held = 1'b0;
            @(negedge clk);
        end
        check("stall_hold", 64'(held), 64'(1));
        wait_done("timeout_stall");

        // Reset while in RD_WAIT at address 3, then a clean run
        do_start(2'b11, 1, 0, '{1'b0, 16'd0, 3'd0});
        k = 0;
        while (!(mem && ready && rw && addr == 3'd3) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) fail_now("timeout_rd3");
        @(negedge clk);
        reset = 1'b0;
        #1 check_reset_vals("abort_reset");
        @(negedge clk);
        check_reset_vals("abort_reset_hold");
        req_q.delete();
        reset = 1'b1;
        @(negedge clk);
        do_start(2'b10, 1, 1, '{1'b1, 16'd0, 3'd0});
        wait_done("timeout_after_abort");

        check("queues_drained", 64'(req_q.size() + res_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
